// File: rtl/exe_forward_hazard_ctrl.sv
// Execute-stage forwarding and hazard controller.
// Keeps a shadow copy of the EX/MEM/WB register-use info and derives the EX
// operand-mux selects, the load-use/RAW stall, the memory-wait freeze and a
// saturating stall-cycle counter.
module exe_forward_hazard_ctrl #(
   parameter int unsigned REG_ADDR_W = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  forwardEn,
   input  logic [REG_ADDR_W-1:0] idSrc1,
   input  logic [REG_ADDR_W-1:0] idSrc2,
   input  logic                  idUseSrc1,
   input  logic                  idTwoSrc,
   input  logic [REG_ADDR_W-1:0] idDest,
   input  logic                  idWbEn,
   input  logic                  idMemREn,
   input  logic                  idMemWEn,
   input  logic                  flush,
   input  logic                  memReady,
   output logic [1:0]            selSrc1,
   output logic [1:0]            selSrc2,
   output logic                  hazard,
   output logic                  freeze,
   output logic [CNT_W-1:0]      stallCount
);

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] src1;
      logic [REG_ADDR_W-1:0] src2;
      logic                  use_src1;
      logic                  two_src;
      logic [REG_ADDR_W-1:0] dest;
      logic                  wb_en;
      logic                  mem_r_en;
      logic                  mem_w_en;
   } slot_t;

   slot_t ex_q, mem_q, wb_q;
   slot_t id_slot;
   logic  m_ex, m_mem;
   logic  hazard_raw;
   logic  [CNT_W-1:0] cnt_q;

   // True when the ID instruction reads a register that slot s will write.
   function automatic logic id_reads(input slot_t s, input logic use1, input logic use2,
                                     input logic [REG_ADDR_W-1:0] a1,
                                     input logic [REG_ADDR_W-1:0] a2);
      return s.valid & s.wb_en & ((use1 & (a1 == s.dest)) | (use2 & (a2 == s.dest)));
   endfunction

   // Operand source for the EX slot; MEM result wins over WB value.
   function automatic logic [1:0] fwd_sel(input logic fen, input slot_t ex, input slot_t mem,
                                          input slot_t wb, input logic use_op,
                                          input logic [REG_ADDR_W-1:0] src);
      logic [1:0] sel;
      sel = 2'd0;
      if (fen && ex.valid && use_op) begin
         if (mem.valid && mem.wb_en && (mem.dest == src)) sel = 2'd1;
         else if (wb.valid && wb.wb_en && (wb.dest == src)) sel = 2'd2;
      end
      return sel;
   endfunction

   // Decode the ID fields into a would-be EX slot and derive stall controls.
   always_comb begin
      id_slot.valid    = 1'b1;
      id_slot.src1     = idSrc1;
      id_slot.src2     = idSrc2;
      id_slot.use_src1 = idUseSrc1;
      id_slot.two_src  = idTwoSrc;
      id_slot.dest     = idDest;
      id_slot.wb_en    = idWbEn;
      id_slot.mem_r_en = idMemREn;
      id_slot.mem_w_en = idMemWEn;

      m_ex  = id_reads(ex_q, idUseSrc1, idTwoSrc, idSrc1, idSrc2);
      m_mem = id_reads(mem_q, idUseSrc1, idTwoSrc, idSrc1, idSrc2);

      freeze = mem_q.valid & (mem_q.mem_r_en | mem_q.mem_w_en) & ~memReady;
      // Forwarding covers everything except a load still in EX; WB never
      // stalls since the register file writes on the opposite edge.
      hazard_raw = forwardEn ? (m_ex & ex_q.mem_r_en) : (m_ex | m_mem);
      hazard     = hazard_raw & ~flush & ~freeze;

      selSrc1 = fwd_sel(forwardEn, ex_q, mem_q, wb_q, ex_q.use_src1, ex_q.src1);
      selSrc2 = fwd_sel(forwardEn, ex_q, mem_q, wb_q, ex_q.two_src, ex_q.src2);

      stallCount = cnt_q;
   end

   // Shadow pipeline advance and saturating stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (!freeze) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= (hazard | flush) ? '0 : id_slot;
         end
         if ((hazard | freeze) && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_exe_forward_hazard_ctrl.sv
// Scoreboard bench for exe_forward_hazard_ctrl: a driver issues directed and
// random ID traffic, predicts outputs from an instruction-level pipeline model
// and queues them; a monitor pops and compares each cycle.
module tb_exe_forward_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst, forwardEn, idUseSrc1, idTwoSrc, idWbEn, idMemREn, idMemWEn;
   logic       flush, memReady;
   logic [3:0] idSrc1, idSrc2, idDest;
   logic [1:0] selSrc1, selSrc2;
   logic       hazard, freeze;
   logic [15:0] stallCount;

   always #5 clk = ~clk;

   exe_forward_hazard_ctrl #(.REG_ADDR_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .forwardEn(forwardEn),
      .idSrc1(idSrc1), .idSrc2(idSrc2), .idUseSrc1(idUseSrc1), .idTwoSrc(idTwoSrc),
      .idDest(idDest), .idWbEn(idWbEn), .idMemREn(idMemREn), .idMemWEn(idMemWEn),
      .flush(flush), .memReady(memReady),
      .selSrc1(selSrc1), .selSrc2(selSrc2), .hazard(hazard), .freeze(freeze),
      .stallCount(stallCount)
   );

   typedef struct {
      bit valid;
      int s1, s2;
      bit u1, u2;
      int d;
      bit wb, ld, st;
   } ins_t;

   typedef struct {
      bit skip;
      bit hz, fz;
      int sel1, sel2;
      int cnt;
      bit mem_ld;
   } exp_t;

   ins_t pipe[3];  // 0 = EX, 1 = MEM, 2 = WB
   int   model_cnt;
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   fen_m = 1'b1;

   function automatic ins_t bubble();
      ins_t b;
      b = '{valid: 0, s1: 0, s2: 0, u1: 0, u2: 0, d: 0, wb: 0, ld: 0, st: 0};
      return b;
   endfunction

   function automatic ins_t mk(int s1, bit u1, int s2, bit u2, int d, bit wb, bit ld, bit st);
      ins_t i;
      i = '{valid: 1, s1: s1, s2: s2, u1: u1, u2: u2, d: d, wb: wb, ld: ld, st: st};
      return i;
   endfunction

   function automatic bit depends(ins_t older, ins_t id);
      return older.valid && older.wb &&
             ((id.u1 && id.s1 == older.d) || (id.u2 && id.s2 == older.d));
   endfunction

   function automatic int pick_src(int src, bit use_op);
      if (!fen_m || !pipe[0].valid || !use_op) return 0;
      for (int k = 1; k <= 2; k++)
         if (pipe[k].valid && pipe[k].wb && pipe[k].d == src) return k;
      return 0;
   endfunction

   task automatic cycle(ins_t id, bit fl, bit mr, bit r);
      exp_t e;
      int   depth;
      @(negedge clk);
      rst = r; forwardEn = fen_m; flush = fl; memReady = mr;
      idSrc1 = id.s1[3:0]; idSrc2 = id.s2[3:0]; idDest = id.d[3:0];
      idUseSrc1 = id.u1; idTwoSrc = id.u2; idWbEn = id.wb;
      idMemREn = id.ld; idMemWEn = id.st;
      #1;
      e.skip   = r;
      e.fz     = pipe[1].valid && (pipe[1].ld || pipe[1].st) && !mr;
      e.hz     = 1'b0;
      depth    = fen_m ? 1 : 2;
      if (!e.fz && !fl)
         for (int k = 0; k < depth; k++)
            if (depends(pipe[k], id) && (!fen_m || pipe[k].ld)) e.hz = 1'b1;
      e.sel1   = pick_src(pipe[0].s1, pipe[0].u1);
      e.sel2   = pick_src(pipe[0].s2, pipe[0].u2);
      e.cnt    = model_cnt;
      e.mem_ld = pipe[1].valid && pipe[1].ld;
      sb.push_back(e);
      if (r) begin
         for (int k = 0; k < 3; k++) pipe[k] = bubble();
         model_cnt = 0;
      end else begin
         if (!e.fz) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (e.hz || fl) ? bubble() : id;
            pipe[0].valid = !(e.hz || fl);
         end
         if ((e.hz || e.fz) && model_cnt < 65535) model_cnt++;
      end
   endtask

   task automatic chk(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   // Monitor: compare queued predictions against DUT outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (!e.skip) begin
               chk("hazard", int'(hazard), int'(e.hz));
               chk("freeze", int'(freeze), int'(e.fz));
               chk("selSrc1", int'(selSrc1), e.sel1);
               chk("selSrc2", int'(selSrc2), e.sel2);
               chk("stallCount", int'(stallCount), e.cnt);
               if (e.mem_ld) begin
                  chk("sel1_vs_mem_load", int'(selSrc1 == 2'd1), 0);
                  chk("sel2_vs_mem_load", int'(selSrc2 == 2'd1), 0);
               end
            end
         end
      end
   end

   initial begin
      ins_t nop, add_r1, sub_r1, ldr_r2, use_r2, wr_r3, rd_r3, str_i, indep;
      int   kind;
      ins_t ri;
      nop    = mk(0, 0, 0, 0, 0, 0, 0, 0);
      add_r1 = mk(4, 1, 5, 1, 1, 1, 0, 0);
      sub_r1 = mk(1, 1, 6, 0, 7, 1, 0, 0);
      indep  = mk(8, 1, 9, 1, 10, 1, 0, 0);
      ldr_r2 = mk(11, 1, 0, 0, 2, 1, 1, 0);
      use_r2 = mk(12, 1, 2, 1, 13, 1, 0, 0);
      wr_r3  = mk(4, 1, 5, 0, 3, 1, 0, 0);
      rd_r3  = mk(3, 1, 3, 1, 14, 1, 0, 0);
      str_i  = mk(6, 1, 9, 1, 0, 0, 0, 1);
      model_cnt = 0;
      for (int k = 0; k < 3; k++) pipe[k] = bubble();

      repeat (2) cycle(nop, 0, 1, 1);
      repeat (3) cycle(nop, 0, 1, 0);

      // Forwarding: MEM, then WB, then MEM-over-WB priority.
      fen_m = 1'b1;
      cycle(add_r1, 0, 1, 0); cycle(sub_r1, 0, 1, 0); cycle(nop, 0, 1, 0);
      cycle(add_r1, 0, 1, 0); cycle(indep, 0, 1, 0); cycle(sub_r1, 0, 1, 0);
      cycle(add_r1, 0, 1, 0); cycle(add_r1, 0, 1, 0); cycle(sub_r1, 0, 1, 0);
      repeat (3) cycle(nop, 0, 1, 0);

      // Load-use: ID held while hazard is up.
      cycle(ldr_r2, 0, 1, 0); cycle(use_r2, 0, 1, 0); cycle(use_r2, 0, 1, 0);
      repeat (3) cycle(nop, 0, 1, 0);

      // Stall-only mode RAW.
      fen_m = 1'b0;
      cycle(wr_r3, 0, 1, 0);
      repeat (3) cycle(rd_r3, 0, 1, 0);
      repeat (3) cycle(nop, 0, 1, 0);
      fen_m = 1'b1;

      // Memory wait on a store, then release.
      cycle(str_i, 0, 1, 0); cycle(nop, 0, 1, 0);
      repeat (4) cycle(nop, 0, 0, 0);
      repeat (2) cycle(nop, 0, 1, 0);

      // Flush against a load-use.
      cycle(ldr_r2, 0, 1, 0); cycle(use_r2, 1, 1, 0); repeat (2) cycle(nop, 0, 1, 0);

      // Reset during freeze.
      cycle(ldr_r2, 0, 1, 0); cycle(nop, 0, 0, 0); cycle(nop, 0, 0, 0);
      cycle(nop, 0, 0, 1); cycle(nop, 0, 0, 0); cycle(nop, 0, 1, 0);

      // Random traffic over a small register window to provoke matches.
      for (int n = 0; n < 1500; n++) begin
         if (n % 100 == 0) fen_m = $urandom_range(0, 1);
         kind = $urandom_range(0, 3);
         ri = mk($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), 0, 0);
         if (kind == 1) begin ri.wb = 1; ri.ld = 1; ri.u2 = 0; end
         else if (kind == 2) begin ri.wb = 0; ri.st = 1; ri.u2 = 1; end
         cycle(ri, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 249) == 0));
      end

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
